msg_block_loader: RTL and testbench
===================================

Name: msg_block_loader

Overview:
- Word-serial message loader for the mining datapath. Accepts message words over a valid/ready stream and writes them MSB-first into 512-bit BRAM blocks, using the Memoria-style strobes (cs_n, wr_n, addr, addr_width).
- Optionally appends SHA-256 padding in hardware: a '1' bit, zeros, then the 64-bit length. Preprocessing can then read complete blocks.
- Replaces bench-side word feeding with a parametrised, synthesizable loader.

Parameters:
- WORD_W, 32, stream/BRAM write word width; one of 8, 16, 32, 64.
- BLOCK_W, 512, block width in bits; fixed at 512.
- MSG_LEN, 1024, message length in bits; multiple of WORD_W, 1 to 2^20.
- ADDR_W, 16, block address width.
- PAD_EN, 1, 1 = append SHA-256 padding; 0 = raw load only.

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- start, input, 1, begin a load; honoured only in IDLE or DONE.
- base_addr, input, ADDR_W, first block address; sampled when start is accepted.
- in_data, input, WORD_W, message word; first word holds the message MSBs.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, loader accepts a word this cycle.
- cs_n, output, 1, BRAM chip select, active-low.
- wr_n, output, 1, BRAM write strobe, active-low.
- addr, output, ADDR_W, target block address.
- addr_width, output, 9, bit index of the word MSB inside the block.
- bram_data_in, output, WORD_W, word to write.
- busy, output, 1, high in LOAD or PAD.
- done, output, 1, high in DONE.
- blocks_written, output, ADDR_W, count of completed blocks in this load.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; in_ready=0, cs_n=1, wr_n=1, addr=0, addr_width=BLOCK_W-1, bram_data_in=0, busy=0, done=0, blocks_written=0; word counters cleared. A reset mid-load abandons the load; partial BRAM content is don't-care.
- States:
  - IDLE/DONE --start--> LOAD. Latch base_addr; addr_width=BLOCK_W-1.
  - LOAD --last message word accepted--> PAD if PAD_EN, else DONE.
  - PAD --last pad word issued--> DONE.
- in_ready = (state==LOAD), combinational. A word is accepted when in_valid&in_ready.
- Write latency is 1 cycle, registered. The cycle after acceptance: cs_n=0, wr_n=0, bram_data_in=word, addr and addr_width give its slot. Otherwise cs_n=wr_n=1.
- In PAD, one pad word is written every cycle, with no input handshake.
- Slot advance after each write:
  - addr_width -= WORD_W.
  - After the write at addr_width==WORD_W-1: addr_width wraps to BLOCK_W-1, addr+=1 (mod 2^ADDR_W), blocks_written+=1.
- Padding (localparams):
  - TOTAL = ceil((MSG_LEN+65)/512)*512.
  - PAD_WORDS = (TOTAL-MSG_LEN)/WORD_W.
  - Pad word 0 = 1 followed by zeros (MSB set).
  - The last 64/WORD_W words are MSG_LEN as a 64-bit big-endian value.
  - All other pad words are zero.
- PAD_EN=0 with MSG_LEN not a multiple of 512: the final block is partial, blocks_written excludes it, and the tail is not written.
- start while busy is ignored.
- start in DONE: done drops the next cycle and LOAD begins.
- in_valid outside LOAD is ignored; no word is consumed.
- Word and pad counters are sized to clog2(MSG_LEN/WORD_W + PAD_WORDS + 1).

Decomposition:
- Package mining_pkg holds:
  - state encoding for IDLE=0, LOAD=1, PAD=2, DONE=3;
  - BLOCK_W=512, LEN_FIELD_W=64;
  - a function computing PAD_WORDS.
- One sub-module, blk_slot_ctr: the addr/addr_width/blocks_written advance-and-wrap counter, shared with the future nonce writer.

Test Plan:
- Defaults (WORD_W=32, MSG_LEN=1024, PAD_EN=1), base_addr=0x10, stream 32 words back-to-back -> 48 writes in total.
  - Message: 32 writes to addrs 0x10–0x11, addr_width 511,479,…,31 per block.
  - Padding to addr 0x12: 0x80000000, 13×0, 0x00000000, 0x00000400.
  - blocks_written=3, done=1.
- MSG_LEN=416 -> 13 message writes plus pad 0x80000000, 0x00000000, 0x000001A0, all in one block; blocks_written=1.
- MSG_LEN=448 (448+65 > 512) -> 18 pad words across 2 blocks; last word 0x000001C0; blocks_written=2.
- Defaults with in_valid toggling randomly (≈50%) -> write sequence identical to the first test; each write exactly 1 cycle after its acceptance; no writes during gaps.
- PAD_EN=0, WORD_W=64, MSG_LEN=1024 -> 16 writes; addr_width 511,447,…,63; blocks_written=2; no pad writes.
- Reset asserted after 10 words, then start -> all outputs return to reset values asynchronously; the new load starts at addr_width 511 from the new base_addr.
- start pulsed mid-load -> ignored; counts unchanged.

Source files
------------

// File: rtl/mining_pkg.sv
// Shared definitions for the mining datapath: loader state encoding, block
// geometry and the SHA-256 padding length helper.
package mining_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int BLOCK_W     = 512;
  localparam int LEN_FIELD_W = 64;

  // Words needed after the message: the '1' marker, zero fill, and the
  // 64-bit length, rounded up to a whole number of blocks.
  function automatic int pad_words(input int msg_len, input int word_w);
    int total;
    total = ((msg_len + LEN_FIELD_W + 1 + BLOCK_W - 1) / BLOCK_W) * BLOCK_W;
    return (total - msg_len) / word_w;
  endfunction

endpackage

// File: rtl/blk_slot_ctr.sv
// Block slot counter: walks the word MSB index down through a block, then
// wraps to the next block address and counts the completed block.
module blk_slot_ctr #(
  parameter int ADDR_W  = 16,
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic [8:0]        addr_width,
  output logic [ADDR_W-1:0] blocks
);

  localparam logic [8:0] TOP_BIT  = 9'(BLOCK_W - 1);
  localparam logic [8:0] LAST_BIT = 9'(WORD_W - 1);
  localparam logic [8:0] STEP     = 9'(WORD_W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      addr_width <= TOP_BIT;
      blocks     <= '0;
    end else if (load) begin
      addr       <= base;
      addr_width <= TOP_BIT;
      blocks     <= '0;
    end else if (advance) begin
      if (addr_width == LAST_BIT) begin
        addr_width <= TOP_BIT;
        addr       <= addr + ADDR_W'(1);
        blocks     <= blocks + ADDR_W'(1);
      end else begin
        addr_width <= addr_width - STEP;
      end
    end
  end

endmodule

// File: rtl/msg_block_loader.sv
// Word-serial message loader: streams message words into 512-bit BRAM blocks
// MSB-first and optionally appends SHA-256 padding in hardware.
module msg_block_loader #(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 512,
  parameter int MSG_LEN = 1024,
  parameter int ADDR_W  = 16,
  parameter int PAD_EN  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cs_n,
  output logic              wr_n,
  output logic [ADDR_W-1:0] addr,
  output logic [8:0]        addr_width,
  output logic [WORD_W-1:0] bram_data_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] blocks_written
);
  import mining_pkg::*;

  localparam int MSG_WORDS = MSG_LEN / WORD_W;
  localparam int PAD_WORDS = pad_words(MSG_LEN, WORD_W);
  localparam int LEN_WORDS = LEN_FIELD_W / WORD_W;
  localparam int CNT_W     = $clog2(MSG_WORDS + PAD_WORDS + 1);
  localparam logic [CNT_W-1:0]       LAST_MSG = CNT_W'(MSG_WORDS - 1);
  localparam logic [CNT_W-1:0]       LAST_PAD = CNT_W'(PAD_WORDS - 1);
  localparam logic [LEN_FIELD_W-1:0] LEN_VAL  = LEN_FIELD_W'(MSG_LEN);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              start_ok, accept, issue_pad;
  logic [WORD_W-1:0] pad_word;
  logic              vld_p1;
  logic [WORD_W-1:0] data_p1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    accept    = 1'b0;
    issue_pad = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          accept = 1'b1;
          if (cnt == LAST_MSG) state_nxt = (PAD_EN != 0) ? ST_PAD : ST_DONE;
        end
      end
      ST_PAD: begin
        issue_pad = 1'b1;
        if (cnt == LAST_PAD) state_nxt = ST_DONE;
      end
      default: ;
    endcase
  end

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state == ST_LOAD) || (state == ST_PAD);
  assign done     = (state == ST_DONE);

  // One counter indexes message words in LOAD and pad words in PAD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start_ok) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (cnt == LAST_MSG) ? '0 : cnt + CNT_W'(1);
    end else if (issue_pad) begin
      cnt <= (cnt == LAST_PAD) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Pad word 0 carries the marker bit; the final LEN_WORDS words carry the
  // big-endian length, most significant slice first.
  always_comb begin
    pad_word = '0;
    if (cnt == '0)
      pad_word[WORD_W-1] = 1'b1;
    else if (int'(cnt) >= PAD_WORDS - LEN_WORDS)
      pad_word = WORD_W'(LEN_VAL >> (WORD_W * (PAD_WORDS - 1 - int'(cnt))));
  end

  // ---- stage p0 -> p1: registered BRAM write ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= accept || issue_pad;
      if (accept)         data_p1 <= in_data;
      else if (issue_pad) data_p1 <= pad_word;
    end
  end

  assign cs_n         = ~vld_p1;
  assign wr_n         = ~vld_p1;
  assign bram_data_in = data_p1;

  blk_slot_ctr #(
    .ADDR_W  (ADDR_W),
    .WORD_W  (WORD_W),
    .BLOCK_W (BLOCK_W)
  ) u_slot (
    .clock      (clock),
    .reset      (reset),
    .load       (start_ok),
    .advance    (vld_p1),
    .base       (base_addr),
    .addr       (addr),
    .addr_width (addr_width),
    .blocks     (blocks_written)
  );

endmodule

// File: tb/tb_msg_block_loader.sv
// Bench for msg_block_loader: four configurations checked every cycle against
// a bit-level model of the expected BRAM write stream.
module tb_msg_block_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start = '0;
  logic [3:0]  valid = '0;
  logic [15:0] base = '0;
  logic [63:0] in_data = '0;

  logic [3:0]  ready, cs_n, wr_n, busy, done;
  logic [15:0] addr [4];
  logic [8:0]  aw   [4];
  logic [63:0] dout [4];
  logic [15:0] bw   [4];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic int ww_of(input int g); return (g == 3) ? 64 : 32; endfunction
  function automatic int ml_of(input int g); return (g == 1) ? 416 : (g == 2) ? 448 : 1024; endfunction
  function automatic int pe_of(input int g); return (g == 3) ? 0 : 1; endfunction
  function automatic int np_of(input int g);
    int ml;
    ml = ml_of(g);
    return pe_of(g) ? (((ml + 65 + 511) / 512) * 512 - ml) / ww_of(g) : 0;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int WW = (g == 3) ? 64 : 32;
    localparam int ML = (g == 1) ? 416 : (g == 2) ? 448 : 1024;
    localparam int PE = (g == 3) ? 0 : 1;
    logic [WW-1:0] din, dw;
    assign din = in_data[WW-1:0];
    msg_block_loader #(
      .WORD_W(WW), .BLOCK_W(512), .MSG_LEN(ML), .ADDR_W(16), .PAD_EN(PE)
    ) u_dut (
      .clock(clk), .reset(rst), .start(start[g]), .base_addr(base),
      .in_data(din), .in_valid(valid[g]), .in_ready(ready[g]),
      .cs_n(cs_n[g]), .wr_n(wr_n[g]), .addr(addr[g]), .addr_width(aw[g]),
      .bram_data_in(dw), .busy(busy[g]), .done(done[g]), .blocks_written(bw[g])
    );
    assign dout[g] = 64'(dw);
  end

  function automatic logic [63:0] word_val(input int i);
    return {32'hC0DE0000 + 32'(i), 32'h5A000000 ^ (32'(i) * 32'h01030507)};
  endfunction

  // Padding from first principles: bit p of the pad stream is the marker,
  // a length bit, or zero.
  function automatic logic [63:0] pad_bits_word(input int ml, input int ww, input int k);
    int padbits, p;
    longint unsigned len;
    logic [63:0] w;
    padbits = ((ml + 65 + 511) / 512) * 512 - ml;
    len = longint'(ml);
    w = '0;
    for (int b = 0; b < ww; b++) begin
      p = k * ww + b;
      if (p == 0) w[ww-1-b] = 1'b1;
      else if (p >= padbits - 64) w[ww-1-b] = len[63-(p-(padbits-64))];
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [8:0]  w;
    logic [63:0] d;
    logic        pad;
  } wr_t;

  wr_t q [4][64];
  int  qh [4], qt [4];
  bit  m_active [4], m_started [4], prev_acc [4], prev_wr [4];
  int  m_acc [4], m_padleft [4], m_wcnt [4];

  function automatic void build_exp(input int g, input logic [15:0] b);
    int ww, n, np;
    wr_t e;
    logic [63:0] mask;
    ww = ww_of(g); n = ml_of(g) / ww; np = np_of(g);
    mask = (ww == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    qh[g] = 0; qt[g] = 0;
    for (int j = 0; j < n + np; j++) begin
      e.a   = b + 16'((j * ww) / 512);
      e.w   = 9'(511 - (j * ww) % 512);
      e.d   = (j < n) ? (word_val(j) & mask) : pad_bits_word(ml_of(g), ww, j - n);
      e.pad = (j >= n);
      q[g][qt[g]] = e;
      qt[g]++;
    end
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      int n, bpb;
      bit exp_wr, acc_now;
      wr_t e;
      n = ml_of(g) / ww_of(g);
      bpb = 512 / ww_of(g);
      if (rst) begin
        check("rst_cs_n", cs_n[g], 1);
        check("rst_wr_n", wr_n[g], 1);
        check("rst_addr", addr[g], 0);
        check("rst_addr_width", aw[g], 511);
        check("rst_data", dout[g], 0);
        check("rst_in_ready", ready[g], 0);
        check("rst_busy", busy[g], 0);
        check("rst_done", done[g], 0);
        check("rst_blocks", bw[g], 0);
        m_active[g] = 0; m_started[g] = 0; m_acc[g] = 0; m_padleft[g] = 0;
        m_wcnt[g] = 0; prev_acc[g] = 0; prev_wr[g] = 0; qh[g] = 0; qt[g] = 0;
      end else begin
        check("in_ready", ready[g], m_active[g] && (m_acc[g] < n));
        check("busy", busy[g], m_active[g]);
        check("done", done[g], m_started[g] && !m_active[g]);
        check("blocks_written", bw[g], 64'(m_wcnt[g] / bpb));
        exp_wr = prev_acc[g] || (prev_wr[g] && (qh[g] < qt[g]) && q[g][qh[g]].pad);
        check("cs_n", cs_n[g], !exp_wr);
        check("wr_n", wr_n[g], !exp_wr);
        if (exp_wr && (qh[g] < qt[g])) begin
          e = q[g][qh[g]];
          qh[g]++;
          check("wr_addr", addr[g], e.a);
          check("wr_addr_width", aw[g], e.w);
          check("wr_data", dout[g], e.d);
          check("wr_kind", e.pad, !prev_acc[g]);
          m_wcnt[g]++;
        end
        acc_now = m_active[g] && (m_acc[g] < n) && valid[g];
        prev_acc[g] = acc_now;
        prev_wr[g]  = exp_wr;
        if (!m_active[g] && start[g]) begin
          build_exp(g, base);
          m_active[g] = 1; m_started[g] = 1; m_acc[g] = 0;
          m_padleft[g] = np_of(g); m_wcnt[g] = 0;
        end else if (m_active[g]) begin
          if (m_acc[g] < n) begin
            if (valid[g]) m_acc[g]++;
          end else begin
            m_padleft[g]--;
          end
          m_active[g] = (m_acc[g] < n) || (m_padleft[g] > 0);
        end
      end
    end
  end

  task automatic run_load(input int g, input logic [15:0] b, input bit rnd,
                          input int feed, input bit pulse);
    int k, cyc;
    bit acc, pulsed;
    @(posedge clk); #1;
    base = b; start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    k = 0; cyc = 0; pulsed = 0;
    while (k < feed && cyc < 1000) begin
      valid[g] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = word_val(k);
      if (pulse && k == 5 && !pulsed) begin
        start[g] = 1'b1; base = 16'h0099; pulsed = 1;
      end
      @(negedge clk);
      acc = valid[g] && ready[g];
      @(posedge clk); #1;
      start[g] = 1'b0;
      if (acc) k++;
      cyc++;
    end
    valid[g] = 1'b0;
    check("feed_complete", 64'(k), 64'(feed));
  endtask

  task automatic finish_check(input int g, input int exp_bw, input logic [15:0] exp_addr);
    int cyc;
    cyc = 0;
    while (!done[g] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("done_reached", done[g], 1);
    repeat (2) @(negedge clk);
    check("final_blocks", bw[g], 64'(exp_bw));
    check("final_addr", addr[g], exp_addr);
    check("final_addr_width", aw[g], 511);
    check("final_done", done[g], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("model_pad0", pad_bits_word(1024, 32, 0), 64'h8000_0000);
    check("model_pad14", pad_bits_word(1024, 32, 14), 64'h0);
    check("model_pad15", pad_bits_word(1024, 32, 15), 64'h400);
    check("model_416_last", pad_bits_word(416, 32, 2), 64'h1A0);
    check("model_448_mid", pad_bits_word(448, 32, 16), 64'h0);
    check("model_448_last", pad_bits_word(448, 32, 17), 64'h1C0);

    run_load(0, 16'h0010, 0, 32, 0);
    finish_check(0, 3, 16'h0013);
    run_load(1, 16'h0020, 0, 13, 0);
    finish_check(1, 1, 16'h0021);
    run_load(2, 16'h0030, 0, 14, 0);
    finish_check(2, 2, 16'h0032);
    run_load(0, 16'h0010, 1, 32, 0);
    finish_check(0, 3, 16'h0013);
    run_load(3, 16'h0040, 0, 16, 0);
    finish_check(3, 2, 16'h0042);

    run_load(0, 16'h0050, 0, 10, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("async_rst_cs_n", cs_n[0], 1);
    check("async_rst_addr", addr[0], 0);
    @(posedge clk); #1 rst = 1'b0;
    run_load(0, 16'h0060, 0, 32, 0);
    finish_check(0, 3, 16'h0063);

    run_load(1, 16'h0070, 0, 13, 1);
    finish_check(1, 1, 16'h0071);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
